// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit producing the HI/LO pair for the execute stage.
// One shift/add (multiply) or restoring shift/subtract (divide) step per cycle on magnitudes.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic                 div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 sgn;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        orig_a_d  = orig_a_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        sgn       = ~op[0];
        a_mag     = (sgn && inpA[WIDTH-1]) ? -inpA : inpA;
        b_mag     = (sgn && inpB[WIDTH-1]) ? -inpB : inpB;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: acc = {partial remainder, dividend bits becoming quotient bits}
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};

        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    div_d     = op[1];
                    orig_a_d  = inpA;
                    opnd_d    = op[1] ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    neg_d     = sgn && (inpA[WIDTH-1] ^ inpB[WIDTH-1]);
                    rem_neg_d = sgn && inpA[WIDTH-1];
                    dz_d      = op[1] && (inpB == '0);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            CALC: begin
                if (div_q) begin
                    acc_d = div_diff[WIDTH]
                          ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d  = orig_a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            orig_a_q  <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            orig_a_q  <= orig_a_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at start, checked when done pulses.
module tb_mult_div_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] inpA, inpB, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .inpA(inpA), .inpB(inpB), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sb64, sp;
        logic signed [31:0] a32, b32;
        logic [63:0] up;
        e = '0;
        a32 = a; b32 = b;
        case (o)
            2'b00: begin
                sa = a32; sb64 = b32; sp = sa * sb64;
                e.hi = sp[63:32]; e.lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32]; e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
                end else if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.hi = 32'd0; e.lo = 32'h80000000;
                end else if (o == 2'b10) begin
                    e.lo = a32 / b32; e.hi = a32 % b32;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // mode 0: plain; 1: start+moves while busy; 2: moves together with start in IDLE
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e, input int mode);
        int n, bc;
        logic seen;
        exp_t got_e;
        @(negedge clk);
        start = 1'b1; op = o; inpA = a; inpB = b;
        if (mode == 2) begin
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
        end
        sb.push_back(e);
        n = 0; bc = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (mode == 1 && n == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD0BAD;
                op = 2'b01; inpA = '1; inpB = '1;
            end
            if (busy) bc++;
            if (n == 20) begin
                chk({tag, "_hold_hi"}, hi, model_hi);
                chk({tag, "_hold_lo"}, lo, model_lo);
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, n, 34);
        chk({tag, "_busy_cycles"}, bc, 33);
        got_e = sb.pop_front();
        chk({tag, "_hi"}, hi, got_e.hi);
        chk({tag, "_lo"}, lo, got_e.lo);
        chk({tag, "_dbz"}, div_by_zero, got_e.dbz);
        model_hi = got_e.hi;
        model_lo = got_e.lo;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        exp_t e;
        int dcnt;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; inpA = '0; inpB = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);

        // reset mid-operation
        start = 1'b1; op = 2'b01; inpA = 32'd5; inpB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort_quiet", dcnt, 0);

        e = '{hi: 32'hFFFFFFFE, lo: 32'h00000001, dbz: 1'b0};
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, e, 0);

        // idle moves
        @(negedge clk); mthi = 1'b1; wdata = 32'hAAAAAAAA;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h55555555;
        chk("mthi_hi", hi, 32'hAAAAAAAA);
        chk("mthi_done", done, 0);
        @(negedge clk); mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h55555555);
        chk("mtlo_hi", hi, 32'hAAAAAAAA);
        chk("mtlo_busy", busy, 0);
        chk("mtlo_done", done, 0);
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h13579BDF;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", hi, 32'h13579BDF);
        chk("mtboth_lo", lo, 32'h13579BDF);
        model_hi = 32'h13579BDF; model_lo = 32'h13579BDF;

        e = '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, dbz: 1'b0};
        run_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'h00000003, e, 0);
        e = '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dbz: 1'b0};
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, e, 0);
        e = '{hi: 32'h12345678, lo: 32'hFFFFFFFF, dbz: 1'b1};
        run_op("divu_zero", 2'b11, 32'h12345678, 32'h00000000, e, 0);
        e = '{hi: 32'h00000001, lo: 32'h00000003, dbz: 1'b0};
        run_op("div_busy_poke", 2'b10, 32'd7, 32'd2, e, 1);
        e = '{hi: 32'h00000000, lo: 32'h00000054, dbz: 1'b0};
        run_op("multu_start_mt", 2'b01, 32'd12, 32'd7, e, 2);
        e = '{hi: 32'h00000000, lo: 32'h80000000, dbz: 1'b0};
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, e, 0);
        e = '{hi: 32'h00000000, lo: 32'hFFFFFFFF, dbz: 1'b1};
        run_op("div_zero_signed", 2'b10, 32'h00000000, 32'h00000000, e, 0);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(1, 100)) : $urandom;
            run_op("rand", ro, ra, rb, model(ro, ra, rb), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the execute stage, beside the 32-bit ALU.
- Takes the same rs/rt operands as the ALU logic units (inpA = rs, inpB = rt) and produces the HI/LO pair.
- HI/LO feed the write-back result mux for MFHI/MFLO.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO; the core stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, shift/add or shift/subtract iterations per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle request to begin an operation.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- inpA  input  WIDTH  rs operand: multiplicand or dividend.
- inpB  input  WIDTH  rt operand: multiplier or divisor.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  output  1  pulses with done when DIV/DIVU had inpB == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0. Reset mid-operation aborts it; no partial result is ever written.
- FSM states: IDLE, CALC, FINISH.
- IDLE: start=1 at edge k latches inpA, inpB and op, clears counter, sets busy=1 and moves to CALC.
  - For signed ops (MULT, DIV), operands are latched as magnitudes and the result sign is recorded.
- CALC: one iteration per edge, edges k+1 .. k+32. Counter runs 0..31; at count 31 the state moves to FINISH.
  - MULT/MULTU: shift/add with a 64-bit accumulator.
  - DIV/DIVU: restoring shift/subtract.
- FINISH (edge k+33):
  - Apply sign correction.
  - Write hi/lo.
  - Set done=1 for exactly one cycle.
  - Clear busy; return to IDLE.
- Timing: busy is high for 33 cycles. done and the new hi/lo are visible in the cycle after edge k+33, 34 cycles after the start cycle.
- Multiply result: {hi,lo} = full 64-bit product, two's-complement for MULT, unsigned for MULTU.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000; no trap.
- Divide by zero (inpB == 0 on DIV/DIVU): still runs the full 34-cycle sequence, then hi = original inpA, lo = 0xFFFFFFFF, div_by_zero=1 together with done.
- start while busy: ignored; no effect on the running operation.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: hi/lo written at that edge, with no done and no busy. mthi and mtlo together write both registers.
- start together with mthi/mtlo in IDLE: start wins and the move is ignored.
- hi/lo hold their values between operations. An operation's new hi/lo appear only at FINISH; before that the previous values remain visible.
- Back-to-back: start may be asserted in the cycle done=1, since state is IDLE by then.

Test Plan:
- Reset hold, then release -> hi=0, lo=0, busy=0, done=0; apply start with rst_n low at edge 10 of an operation -> busy=0 next cycle, hi/lo unchanged (0).
- MULTU inpA=0xFFFFFFFF, inpB=0xFFFFFFFF -> busy for 33 cycles; done at start+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT inpA=0xFFFFFFFE (-2), inpB=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV inpA=0xFFFFFFF9 (-7), inpB=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU inpA=0x12345678, inpB=0 -> done with div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF.
- Idle mthi with wdata=0xAAAAAAAA, then mtlo with wdata=0x55555555 -> hi=0xAAAAAAAA, lo=0x55555555, no done.
- start plus mthi while busy -> both ignored, first result intact.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
